// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle controller: instruction fields, strobe encodings,
// branch conditions and the controller state set.
package cpu_ctrl_pkg;

  localparam logic [2:0] OPC_B    = 3'b001;
  localparam logic [2:0] OPC_BL   = 3'b010;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;
  localparam logic [1:0] OP_B       = 2'b00;
  localparam logic [1:0] OP_BX      = 2'b00;
  localparam logic [1:0] OP_BL      = 2'b11;

  localparam logic [1:0] NSEL_RN = 2'b00;
  localparam logic [1:0] NSEL_RD = 2'b01;
  localparam logic [1:0] NSEL_RM = 2'b10;

  localparam logic [1:0] VSEL_MDATA  = 2'b00;
  localparam logic [1:0] VSEL_SXIMM8 = 2'b01;
  localparam logic [1:0] VSEL_PC     = 2'b10;
  localparam logic [1:0] VSEL_C      = 2'b11;

  localparam logic [1:0] PCSEL_INC  = 2'b00;
  localparam logic [1:0] PCSEL_REL  = 2'b01;
  localparam logic [1:0] PCSEL_REG  = 2'b10;
  localparam logic [1:0] PCSEL_ZERO = 2'b11;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_LE = 3'b100;

  typedef enum logic [4:0] {
    S_RESET, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE,
    S_WRITE_IMM, S_GET_A, S_GET_B, S_CALC, S_CALC_A0, S_WRITE_REG, S_CMP,
    S_MEM_ADDR, S_LOAD_ADDR, S_MEM_RD, S_WB_MEM, S_GET_RD, S_STR_PASS, S_MEM_WR,
    S_BRANCH, S_LINK, S_JUMP_REG, S_HALT
  } state_t;

  // Returns {legal, taken}; codes above LE are reserved encodings.
  function automatic logic [1:0] cond_eval(input logic [2:0] cond, input logic z, n, v);
    logic [1:0] r;
    r = 2'b00;
    case (cond)
      COND_AL: r = 2'b11;
      COND_EQ: r = {1'b1, z};
      COND_NE: r = {1'b1, ~z};
      COND_LT: r = {1'b1, n ^ v};
      COND_LE: r = {1'b1, (n ^ v) | z};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Decoder/status inputs and datapath control strobes of the controller, grouped as one bundle.
interface cpu_ctrl_fsm_if;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] cond;
  logic       Z, N, V;
  logic [1:0] nsel, vsel, pcsel, mem_cmd;
  logic       loada, loadb, loadc, loads, write, asel, bsel;
  logic       loadir, loadpc, load_addr, addr_sel, halted, err;

  modport master (
    input  opcode, op, cond, Z, N, V,
    output nsel, vsel, pcsel, mem_cmd, loada, loadb, loadc, loads, write, asel, bsel,
           loadir, loadpc, load_addr, addr_sel, halted, err
  );

  modport slave (
    output opcode, op, cond, Z, N, V,
    input  nsel, vsel, pcsel, mem_cmd, loada, loadb, loadc, loads, write, asel, bsel,
           loadir, loadpc, load_addr, addr_sel, halted, err
  );
endinterface

// File: rtl/DFlipFlop.sv
// Generic register with asynchronous active-high reset to a configurable value.
module DFlipFlop #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= RST_VAL;
    else       q <= d;
  end
endmodule

// File: rtl/mem_wait_counter.sv
// Memory wait-state down-counter: load has priority, decrement saturates at zero.
module mem_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - CNT_W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Moore multicycle controller: fetch/decode/execute sequencing with memory wait states,
// branches, halt and illegal-encoding trap.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic            clk,
  input  logic            reset,
  cpu_ctrl_fsm_if.master  bus
);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  state_t     state, state_n;
  logic [4:0] state_q;
  logic       cnt_load, cnt_zero, set_err, err_q;
  logic [1:0] br;

  DFlipFlop #(.W(5), .RST_VAL(S_RESET)) u_state (
    .clk(clk), .reset(reset), .d(state_n), .q(state_q)
  );
  assign state = state_t'(state_q);

  // Reload only on entry so the count runs down while the state is held.
  assign cnt_load = (state_n == S_IF1    && state != S_IF1) ||
                    (state_n == S_MEM_RD && state != S_MEM_RD);

  mem_wait_counter #(.CNT_W(CNT_W)) u_wait (
    .clk(clk), .reset(reset), .load(cnt_load),
    .dec(state == S_IF1 || state == S_MEM_RD),
    .load_val(LAT_M1), .zero(cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err_q <= 1'b0;
    else if (set_err) err_q <= 1'b1;
  end

  assign br = cond_eval(bus.cond, bus.Z, bus.N, bus.V);

  always_comb begin
    state_n = state;
    set_err = 1'b0;
    case (state)
      S_RESET:     state_n = S_IF1;
      S_IF1:       state_n = cnt_zero ? S_IF2 : S_IF1;
      S_IF2:       state_n = S_UPDATE_PC;
      S_UPDATE_PC: state_n = S_DECODE;
      S_DECODE: begin
        state_n = S_HALT;
        set_err = 1'b1;
        case (bus.opcode)
          OPC_HALT: set_err = 1'b0;
          OPC_MOV: begin
            if (bus.op == OP_MOV_IMM)      begin state_n = S_WRITE_IMM; set_err = 1'b0; end
            else if (bus.op == OP_MOV_REG) begin state_n = S_GET_B;     set_err = 1'b0; end
          end
          OPC_ALU: begin
            set_err = 1'b0;
            case (bus.op)
              OP_ADD, OP_AND, OP_CMP: state_n = S_GET_A;
              OP_MVN:                 state_n = S_GET_B;
              default:                state_n = S_HALT;
            endcase
          end
          OPC_LDR, OPC_STR:
            if (bus.op == OP_MEM) begin state_n = S_GET_A; set_err = 1'b0; end
          OPC_B:
            if (bus.op == OP_B && br[1]) begin
              state_n = br[0] ? S_BRANCH : S_IF1;
              set_err = 1'b0;
            end
          OPC_BL: begin
            if (bus.op == OP_BL)      begin state_n = S_LINK;     set_err = 1'b0; end
            else if (bus.op == OP_BX) begin state_n = S_JUMP_REG; set_err = 1'b0; end
          end
          default: ;
        endcase
      end
      S_GET_A:     state_n = (bus.opcode == OPC_LDR || bus.opcode == OPC_STR) ? S_MEM_ADDR : S_GET_B;
      S_GET_B: begin
        if (bus.opcode == OPC_MOV || bus.op == OP_MVN) state_n = S_CALC_A0;
        else if (bus.op == OP_CMP)                     state_n = S_CMP;
        else                                           state_n = S_CALC;
      end
      S_CALC, S_CALC_A0: state_n = S_WRITE_REG;
      S_MEM_ADDR:  state_n = S_LOAD_ADDR;
      S_LOAD_ADDR: state_n = (bus.opcode == OPC_LDR) ? S_MEM_RD : S_GET_RD;
      S_MEM_RD:    state_n = cnt_zero ? S_WB_MEM : S_MEM_RD;
      S_GET_RD:    state_n = S_STR_PASS;
      S_STR_PASS:  state_n = S_MEM_WR;
      S_LINK:      state_n = S_BRANCH;
      S_HALT:      state_n = S_HALT;
      default:     state_n = S_IF1;
    endcase
  end

  always_comb begin
    bus.nsel = NSEL_RN;   bus.vsel = VSEL_MDATA; bus.pcsel = PCSEL_INC; bus.mem_cmd = MEM_NONE;
    bus.loada = 1'b0;     bus.loadb = 1'b0;      bus.loadc = 1'b0;      bus.loads = 1'b0;
    bus.write = 1'b0;     bus.asel = 1'b0;       bus.bsel = 1'b0;       bus.loadir = 1'b0;
    bus.loadpc = 1'b0;    bus.load_addr = 1'b0;  bus.addr_sel = 1'b0;
    bus.halted = (state == S_HALT);
    bus.err = err_q;
    case (state)
      S_RESET:     begin bus.loadpc = 1'b1; bus.pcsel = PCSEL_ZERO; end
      S_IF1:       begin bus.addr_sel = 1'b1; bus.mem_cmd = MEM_READ; end
      S_IF2:       begin bus.addr_sel = 1'b1; bus.mem_cmd = MEM_READ; bus.loadir = 1'b1; end
      S_UPDATE_PC: begin bus.loadpc = 1'b1; bus.pcsel = PCSEL_INC; end
      S_WRITE_IMM: begin bus.nsel = NSEL_RN; bus.vsel = VSEL_SXIMM8; bus.write = 1'b1; end
      S_GET_A:     begin bus.nsel = NSEL_RN; bus.loada = 1'b1; end
      S_GET_B:     begin bus.nsel = NSEL_RM; bus.loadb = 1'b1; end
      S_CALC:      bus.loadc = 1'b1;
      S_CALC_A0, S_STR_PASS: begin bus.asel = 1'b1; bus.loadc = 1'b1; end
      S_WRITE_REG: begin bus.nsel = NSEL_RD; bus.vsel = VSEL_C; bus.write = 1'b1; end
      S_CMP:       bus.loads = 1'b1;
      S_MEM_ADDR:  begin bus.bsel = 1'b1; bus.loadc = 1'b1; end
      S_LOAD_ADDR: bus.load_addr = 1'b1;
      S_MEM_RD:    bus.mem_cmd = MEM_READ;
      S_WB_MEM:    begin bus.nsel = NSEL_RD; bus.vsel = VSEL_MDATA; bus.write = 1'b1; bus.mem_cmd = MEM_READ; end
      S_GET_RD:    begin bus.nsel = NSEL_RD; bus.loadb = 1'b1; end
      S_MEM_WR:    bus.mem_cmd = MEM_WRITE;
      S_BRANCH:    begin bus.loadpc = 1'b1; bus.pcsel = PCSEL_REL; end
      S_LINK:      begin bus.nsel = NSEL_RN; bus.vsel = VSEL_PC; bus.write = 1'b1; end
      S_JUMP_REG:  begin bus.nsel = NSEL_RD; bus.loadpc = 1'b1; bus.pcsel = PCSEL_REG; end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm at MEM_LAT 1, 2 and 3: directed scenarios plus a random instruction
// stream, each checked cycle by cycle against a per-instruction step list built from the ISA rules.
module tb_cpu_ctrl_fsm;

  typedef struct packed {
    logic [1:0] nsel;
    logic [1:0] vsel;
    logic loada, loadb, loadc, loads, write, asel, bsel, loadir, loadpc, load_addr;
    logic [1:0] pcsel;
    logic addr_sel;
    logic [1:0] mem_cmd;
    logic halted, err;
  } ov_t;

  localparam int T_RST = 0, T_IF1 = 1, T_IF2 = 2, T_UPD = 3, T_DEC = 4, T_WIMM = 5,
                 T_GETA = 6, T_GETB = 7, T_CALC = 8, T_CALCA0 = 9, T_WREG = 10, T_CMP = 11,
                 T_MADDR = 12, T_LADDR = 13, T_MRD = 14, T_WBM = 15, T_GETRD = 16,
                 T_SPASS = 17, T_MWR = 18, T_BR = 19, T_LINK = 20, T_JREG = 21, T_HALT = 22;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] opcode, cond;
  logic [1:0] op;
  logic z, n, v;

  cpu_ctrl_fsm_if b1 ();
  cpu_ctrl_fsm_if b2 ();
  cpu_ctrl_fsm_if b3 ();

  assign b1.opcode = opcode; assign b1.op = op; assign b1.cond = cond;
  assign b1.Z = z; assign b1.N = n; assign b1.V = v;
  assign b2.opcode = opcode; assign b2.op = op; assign b2.cond = cond;
  assign b2.Z = z; assign b2.N = n; assign b2.V = v;
  assign b3.opcode = opcode; assign b3.op = op; assign b3.cond = cond;
  assign b3.Z = z; assign b3.N = n; assign b3.V = v;

  cpu_ctrl_fsm #(.MEM_LAT(1), .CNT_W(4)) u1 (.clk(clk), .reset(reset), .bus(b1.master));
  cpu_ctrl_fsm #(.MEM_LAT(2), .CNT_W(4)) u2 (.clk(clk), .reset(reset), .bus(b2.master));
  cpu_ctrl_fsm #(.MEM_LAT(3), .CNT_W(4)) u3 (.clk(clk), .reset(reset), .bus(b3.master));

  ov_t o1, o2, o3;
  assign o1 = {b1.nsel, b1.vsel, b1.loada, b1.loadb, b1.loadc, b1.loads, b1.write, b1.asel,
               b1.bsel, b1.loadir, b1.loadpc, b1.load_addr, b1.pcsel, b1.addr_sel, b1.mem_cmd,
               b1.halted, b1.err};
  assign o2 = {b2.nsel, b2.vsel, b2.loada, b2.loadb, b2.loadc, b2.loads, b2.write, b2.asel,
               b2.bsel, b2.loadir, b2.loadpc, b2.load_addr, b2.pcsel, b2.addr_sel, b2.mem_cmd,
               b2.halted, b2.err};
  assign o3 = {b3.nsel, b3.vsel, b3.loada, b3.loadb, b3.loadc, b3.loads, b3.write, b3.asel,
               b3.bsel, b3.loadir, b3.loadpc, b3.load_addr, b3.pcsel, b3.addr_sel, b3.mem_cmd,
               b3.halted, b3.err};

  always #5 clk = ~clk;

  int  total = 0, bad = 0;
  ov_t got_q[$], exp_q[$];
  int  stp_q[$];
  bit  last_halt;
  ov_t rst_a, rst_r;

  function automatic ov_t obs(input int lat);
    return (lat == 1) ? o1 : (lat == 2) ? o2 : o3;
  endfunction

  // Strobes each step is documented to raise; everything else stays 0.
  function automatic ov_t ov(input int s, input logic e);
    ov_t r = '0;
    case (s)
      T_RST:    begin r.loadpc = 1; r.pcsel = 2'b11; end
      T_IF1:    begin r.addr_sel = 1; r.mem_cmd = 2'b01; end
      T_IF2:    begin r.addr_sel = 1; r.mem_cmd = 2'b01; r.loadir = 1; end
      T_UPD:    r.loadpc = 1;
      T_WIMM:   begin r.vsel = 2'b01; r.write = 1; end
      T_GETA:   r.loada = 1;
      T_GETB:   begin r.nsel = 2'b10; r.loadb = 1; end
      T_CALC:   r.loadc = 1;
      T_CALCA0: begin r.asel = 1; r.loadc = 1; end
      T_WREG:   begin r.nsel = 2'b01; r.vsel = 2'b11; r.write = 1; end
      T_CMP:    r.loads = 1;
      T_MADDR:  begin r.bsel = 1; r.loadc = 1; end
      T_LADDR:  r.load_addr = 1;
      T_MRD:    r.mem_cmd = 2'b01;
      T_WBM:    begin r.nsel = 2'b01; r.write = 1; r.mem_cmd = 2'b01; end
      T_GETRD:  begin r.nsel = 2'b01; r.loadb = 1; end
      T_SPASS:  begin r.asel = 1; r.loadc = 1; end
      T_MWR:    r.mem_cmd = 2'b10;
      T_BR:     begin r.loadpc = 1; r.pcsel = 2'b01; end
      T_LINK:   begin r.vsel = 2'b10; r.write = 1; end
      T_JREG:   begin r.nsel = 2'b01; r.loadpc = 1; r.pcsel = 2'b10; end
      T_HALT:   begin r.halted = 1; r.err = e; end
      default: ;
    endcase
    return r;
  endfunction

  // Drives one instruction from its first IF1 cycle and records observed/expected per cycle.
  // Returns at the negedge after the last step, or right after step index 'stop'.
  task automatic exec_instr(input int lat, input logic [2:0] oc, input logic [1:0] o,
                            input logic [2:0] c, input logic fz, fn, fv, input int stop);
    int   s[$];
    logic e;
    bit   tk;
    got_q.delete(); exp_q.delete(); stp_q.delete();
    opcode = oc; op = o; cond = c; z = fz; n = fn; v = fv;
    e = 1'b0; last_halt = 0;
    repeat (lat) s.push_back(T_IF1);
    s.push_back(T_IF2); s.push_back(T_UPD); s.push_back(T_DEC);
    case (c)
      3'd0: tk = 1;
      3'd1: tk = fz;
      3'd2: tk = !fz;
      3'd3: tk = fn ^ fv;
      default: tk = (fn ^ fv) | fz;
    endcase
    if (oc == 3'b111) last_halt = 1;
    else if ({oc, o} == 5'b110_10) s.push_back(T_WIMM);
    else if ({oc, o} == 5'b110_00 || {oc, o} == 5'b101_11) begin
      s.push_back(T_GETB); s.push_back(T_CALCA0); s.push_back(T_WREG);
    end else if ({oc, o} == 5'b101_00 || {oc, o} == 5'b101_10) begin
      s.push_back(T_GETA); s.push_back(T_GETB); s.push_back(T_CALC); s.push_back(T_WREG);
    end else if ({oc, o} == 5'b101_01) begin
      s.push_back(T_GETA); s.push_back(T_GETB); s.push_back(T_CMP);
    end else if ({oc, o} == 5'b011_00) begin
      s.push_back(T_GETA); s.push_back(T_MADDR); s.push_back(T_LADDR);
      repeat (lat) s.push_back(T_MRD);
      s.push_back(T_WBM);
    end else if ({oc, o} == 5'b100_00) begin
      s.push_back(T_GETA); s.push_back(T_MADDR); s.push_back(T_LADDR);
      s.push_back(T_GETRD); s.push_back(T_SPASS); s.push_back(T_MWR);
    end else if ({oc, o} == 5'b001_00 && c <= 3'd4) begin
      if (tk) s.push_back(T_BR);
    end else if ({oc, o} == 5'b010_11) begin
      s.push_back(T_LINK); s.push_back(T_BR);
    end else if ({oc, o} == 5'b010_00) s.push_back(T_JREG);
    else begin last_halt = 1; e = 1'b1; end
    if (last_halt) repeat (20) s.push_back(T_HALT);
    for (int i = 0; i < s.size(); i++) begin
      got_q.push_back(obs(lat)); exp_q.push_back(ov(s[i], e)); stp_q.push_back(s[i]);
      if (i == stop) return;
      @(negedge clk);
    end
  endtask

  // Asserts reset off-edge, samples outputs 1 ns later and again in the released RESET cycle.
  task automatic do_reset(input int lat);
    reset = 1'b1;
    #1 rst_a = obs(lat);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rst_r = obs(lat);
    @(negedge clk);
  endtask

  task automatic test_reset();
    opcode = 3'b110; op = 2'b10; cond = 3'd0; z = 0; n = 0; v = 0;
    do_reset(1);
    total++; if (rst_a !== ov(T_RST, 0)) begin bad++; $display("FAIL reset_assert got=%h want=%h", rst_a, ov(T_RST, 0)); end
    total++; if (rst_r !== ov(T_RST, 0)) begin bad++; $display("FAIL reset_release got=%h want=%h", rst_r, ov(T_RST, 0)); end
    total++; if (o1 !== ov(T_IF1, 0)) begin bad++; $display("FAIL reset_first_if1 got=%h want=%h", o1, ov(T_IF1, 0)); end
  endtask

  task automatic test_mov_imm_lat3();
    do_reset(3);
    exec_instr(3, 3'b110, 2'b10, 3'd0, 0, 0, 0, -1);
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL mov_imm_lat3 cyc=%0d step=%0d got=%h want=%h", i, stp_q[i], got_q[i], exp_q[i]); end
    end
    total++; if (o3 !== ov(T_IF1, 0)) begin bad++; $display("FAIL mov_imm_next_if1 got=%h want=%h", o3, ov(T_IF1, 0)); end
  endtask

  task automatic test_add();
    do_reset(1);
    exec_instr(1, 3'b101, 2'b00, 3'd0, 0, 0, 0, -1);
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL add cyc=%0d step=%0d got=%h want=%h", i, stp_q[i], got_q[i], exp_q[i]); end
    end
    total++; if (o1 !== ov(T_IF1, 0)) begin bad++; $display("FAIL add_if1_at_cycle8 got=%h want=%h", o1, ov(T_IF1, 0)); end
  endtask

  task automatic test_cmp_branch();
    do_reset(1);
    for (int k = 0; k < 2; k++) begin
      exec_instr(1, 3'b101, 2'b01, 3'd0, 0, 0, 0, -1);
      for (int i = 0; i < got_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL cmp cyc=%0d step=%0d got=%h want=%h", i, stp_q[i], got_q[i], exp_q[i]); end
      end
      exec_instr(1, 3'b001, 2'b00, 3'd1, (k == 0), 0, 0, -1);
      for (int i = 0; i < got_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL beq_z%0d cyc=%0d step=%0d got=%h want=%h", (k == 0), i, stp_q[i], got_q[i], exp_q[i]); end
      end
      total++; if (o1 !== ov(T_IF1, 0)) begin bad++; $display("FAIL beq_next_if1 got=%h want=%h", o1, ov(T_IF1, 0)); end
    end
  endtask

  task automatic test_ldr_str_lat2();
    do_reset(2);
    exec_instr(2, 3'b011, 2'b00, 3'd0, 0, 0, 0, -1);
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL ldr_lat2 cyc=%0d step=%0d got=%h want=%h", i, stp_q[i], got_q[i], exp_q[i]); end
    end
    exec_instr(2, 3'b100, 2'b00, 3'd0, 0, 0, 0, -1);
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL str_lat2 cyc=%0d step=%0d got=%h want=%h", i, stp_q[i], got_q[i], exp_q[i]); end
    end
    total++; if (o2 !== ov(T_IF1, 0)) begin bad++; $display("FAIL str_single_memwr got=%h want=%h", o2, ov(T_IF1, 0)); end
  endtask

  task automatic test_bl_bx();
    do_reset(1);
    exec_instr(1, 3'b010, 2'b11, 3'd5, 0, 0, 0, -1);
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bl cyc=%0d step=%0d got=%h want=%h", i, stp_q[i], got_q[i], exp_q[i]); end
    end
    exec_instr(1, 3'b010, 2'b00, 3'd0, 0, 0, 0, -1);
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bx cyc=%0d step=%0d got=%h want=%h", i, stp_q[i], got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_halt();
    do_reset(1);
    exec_instr(1, 3'b111, 2'b01, 3'd0, 0, 0, 0, -1);
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL halt cyc=%0d step=%0d got=%h want=%h", i, stp_q[i], got_q[i], exp_q[i]); end
    end
    do_reset(1);
    exec_instr(1, 3'b000, 2'b00, 3'd0, 0, 0, 0, -1);
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL illegal cyc=%0d step=%0d got=%h want=%h", i, stp_q[i], got_q[i], exp_q[i]); end
    end
    do_reset(1);
    total++; if (rst_a !== ov(T_RST, 0)) begin bad++; $display("FAIL err_clear got=%h want=%h", rst_a, ov(T_RST, 0)); end
  endtask

  task automatic test_reset_mid_str();
    do_reset(1);
    exec_instr(1, 3'b100, 2'b00, 3'd0, 0, 0, 0, 9);
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL str_pre_abort cyc=%0d step=%0d got=%h want=%h", i, stp_q[i], got_q[i], exp_q[i]); end
    end
    #2 do_reset(1);
    total++; if (rst_a !== ov(T_RST, 0)) begin bad++; $display("FAIL abort_memwr got=%h want=%h", rst_a, ov(T_RST, 0)); end
    exec_instr(1, 3'b110, 2'b10, 3'd0, 0, 0, 0, -1);
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL after_abort cyc=%0d step=%0d got=%h want=%h", i, stp_q[i], got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [4:0] enc;
    int k;
    for (int lat = 1; lat <= 3; lat++) begin
      do_reset(lat);
      repeat (30) begin
        k = $urandom_range(0, 11);
        case (k)
          0: enc = 5'b110_10;  1: enc = 5'b110_00;  2: enc = 5'b101_00;  3: enc = 5'b101_01;
          4: enc = 5'b101_10;  5: enc = 5'b101_11;  6: enc = 5'b011_00;  7: enc = 5'b100_00;
          8: enc = 5'b001_00;  9: enc = 5'b010_11;  10: enc = 5'b010_00;
          default: enc = 5'($urandom);
        endcase
        exec_instr(lat, enc[4:2], enc[1:0], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        for (int i = 0; i < got_q.size(); i++) begin
          total++;
          if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL random lat=%0d enc=%b cyc=%0d step=%0d got=%h want=%h", lat, enc, i, stp_q[i], got_q[i], exp_q[i]); end
        end
        if (last_halt) begin
          do_reset(lat);
          total++; if (rst_r !== ov(T_RST, 0)) begin bad++; $display("FAIL random_reset lat=%0d got=%h want=%h", lat, rst_r, ov(T_RST, 0)); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mov_imm_lat3();
    test_add();
    test_cmp_branch();
    test_ldr_str_lat2();
    test_bl_bx();
    test_halt();
    test_reset_mid_str();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Parametrised multicycle controller for the 16-bit RISC core. It sequences instruction fetch, PC update, decode and execute for MOV, ALU, LDR and STR. It also adds conditional branches, BL/BX, HALT, illegal-opcode trapping and a configurable memory wait-state count. It sits between the instruction decoder/status register and the datapath, program counter and memory interface, and drives only the control strobes.

## Interface
- MEM_LAT, 1: memory read latency in cycles, legal range 1..2^CNT_W.
- CNT_W, 4: width of the wait-state counter.
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces state RESET immediately.
- opcode  in  3  instruction bits [15:13], from the instruction register.
- op  in  2  instruction bits [12:11].
- cond  in  3  instruction bits [10:8], branch condition.
- Z, N, V  in  1 each  registered status flags.
- nsel  out  2  register select: RN=00, RD=01, RM=10.
- vsel  out  2  write-back source: MDATA=00, SXIMM8=01, PC=10, C=11.
- loada, loadb, loadc, loads, write, asel, bsel, loadir, loadpc, load_addr  out  1 each  datapath strobes.
- pcsel  out  2  next-PC source: INC=00, REL (PC+sximm8)=01, REG (Rd read data)=10, ZERO=11.
- addr_sel  out  1  memory address source: 1 = PC, 0 = data address register.
- mem_cmd  out  2  memory command: NONE=00, READ=01, WRITE=10.
- halted  out  1  core stopped.
- err  out  1  core stopped on an illegal encoding.

## Operation
- Moore machine: every output decodes from the current state only; any strobe not listed for a state is 0.
- RESET: loadpc=1, pcsel=ZERO, all else 0 → IF1.
- Fetch sequence:
  - IF1: addr_sel=1, mem_cmd=READ. Stay while wait_cnt≠0, decrementing; at 0 → IF2.
  - IF2: addr_sel=1, mem_cmd=READ, loadir=1 → UPDATE_PC.
  - UPDATE_PC: loadpc, pcsel=INC → DECODE.
  - DECODE: no strobes; dispatches on {opcode, op, cond, flags}.
- wait_cnt is loaded with MEM_LAT-1 on every entry to IF1 or MEM_RD.
- Dispatch from DECODE (every execute path ends → IF1):
  - MOV imm (110/10): WRITE_IMM (nsel=RN, vsel=SXIMM8, write).
  - MOV reg (110/00) and MVN (101/11): GET_B → CALC_A0 (asel=1, bsel=0, loadc) → WRITE_REG.
  - ADD (101/00) and AND (101/10): GET_A → GET_B → CALC (asel=0, bsel=0, loadc) → WRITE_REG.
  - CMP (101/01): GET_A → GET_B → CMP (loads).
  - LDR (011/00): GET_A → MEM_ADDR (bsel=1, loadc) → LOAD_ADDR (load_addr) → MEM_RD (addr_sel=0, READ, waits like IF1) → WB_MEM (nsel=RD, vsel=MDATA, write, READ held).
  - STR (100/00): GET_A → MEM_ADDR → LOAD_ADDR → GET_RD (nsel=RD, loadb) → STR_PASS (asel=1, bsel=0, loadc) → MEM_WR (addr_sel=0, WRITE, one cycle).
  - B (001/00): taken → BRANCH (loadpc, pcsel=REL); not taken → IF1.
  - BL (010/11): LINK (nsel=RN, vsel=PC, write) → BRANCH.
  - BX (010/00): JUMP_REG (nsel=RD, loadpc, pcsel=REG).
  - HALT (111): → HALT.
  - Any other encoding: → HALT with err latched to 1.
- Register-access states:
  - GET_A: nsel=RN, loada.
  - GET_B: nsel=RM, loadb.
  - WRITE_REG: nsel=RD, vsel=C, write.
- Branch conditions: 000 always; 001 Z; 010 !Z; 011 N≠V; 100 (N≠V)|Z; 101–111 illegal.
- HALT: halted=1 (err as latched), no strobes; exit only by reset.

## Timing
- Reset asserted: state, wait_cnt and err clear asynchronously. Outputs show RESET values that same cycle (loadpc=1, pcsel=11, others 0), so an in-flight write or mem WRITE aborts.
- First IF1 is the cycle after reset deasserts and the RESET state completes.
- Fetch overhead: IF1 (MEM_LAT cycles) + IF2 + UPDATE_PC + DECODE = MEM_LAT+3.
- Execute cycles with MEM_LAT=1:
  - MOV imm 1; MOV reg/MVN 3; ADD/AND 4; CMP 3.
  - LDR 5+(MEM_LAT-1); STR 6.
  - B taken 1, not taken 0; BL 2; BX 1.
- Flags are sampled in DECODE only. A CMP immediately before a branch is valid because loads commits at the end of the CMP state.

## Structure
- Package cpu_ctrl_pkg holds:
  - opcode/op constants;
  - nsel, vsel, pcsel and mem_cmd encodings;
  - condition codes;
  - the state enum.
- Sub-module mem_wait_counter (load, decrement, zero flag; CNT_W wide) is shared by IF1 and MEM_RD.
- State register uses the codebase DFlipFlop with the async reset override.

## Test plan
- Reset mid-STR (in MEM_WR): mem_cmd drops to 00 the same cycle, loadpc=1, pcsel=11; after release, IF1 starts.
- MEM_LAT=3, MOV R0,#5: IF1 held 3 cycles, then IF2/UPDATE_PC/DECODE, then WRITE_IMM with nsel=00, vsel=01, write=1. Total 7 cycles.
- ADD R2,R1,R0: GET_A, GET_B, CALC, WRITE_REG in order, with nsel 00, 10, -, 01. Next IF1 at cycle 8 after the start of the fetch.
- CMP then BEQ with Z=1 → BRANCH (pcsel=01). The same sequence with Z=0 → IF1 straight after DECODE.
- LDR with MEM_LAT=2: MEM_RD lasts 2 cycles with addr_sel=0, then WB_MEM vsel=00, write=1. STR: MEM_WR exactly one cycle with mem_cmd=10.
- opcode 111 → halted=1, err=0, held 20 cycles. opcode 000 → halted=1, err=1. Reset clears both.
